random_request_arbiter: RTL and testbench
=========================================

// Module: random_request_arbiter
// PURPOSE
//  Shares the single 4-bit keystroke-driven random source between several game
//  requesters (lane spawners, hazard timers). Round-robin arbitration; one winner
//  per grant. Captures the random value and folds it into a per-game range
//  0..max_val. Enforces a GAP-cycle spacing after each grant so the random source
//  advances between consecutive draws.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  RAND_W   4  width of random source / output value
//  GAP      2  idle cycles forced after each grant (0..15); 0 = back-to-back allowed
// PORTS
//  clk       in   1        system clock
//  reset     in   1        synchronous reset, active-high
//  req       in   NUM_REQ  level request per requester; held until granted
//  rand_in   in   RAND_W   current value of random generator
//  max_val   in   RAND_W   inclusive upper bound of delivered value
//  gnt       out  NUM_REQ  one-hot grant, 1-cycle pulse, registered
//  rand_out  out  RAND_W   folded random value, valid only while |gnt
//  busy      out  1        high whenever state != IDLE
//  grant_cnt out  8        total grants since reset, wraps 255->0
// BEHAVIOUR
//  Reset (sampled on clk rising edge while reset=1):
//   - state=IDLE, gnt=0, rand_out=0, busy=0, grant_cnt=0, rr_ptr=0, gap_cnt=0.
//   - Overrides everything, incl. mid-GRANT/WAIT. Outputs are 0 on the first
//     cycle after the edge.
//  FSM states IDLE, GRANT, WAIT:
//   - IDLE: at edge k with req!=0, pick winner, capture rand_in -> GRANT at k+1.
//     Else stay IDLE.
//   - GRANT: exactly one cycle; gnt[winner]=1, rand_out valid.
//     Next state WAIT if GAP>0, else IDLE.
//   - WAIT: gap_cnt loaded with GAP-1 on entry, decrements each cycle.
//     Go to IDLE when gap_cnt==0; req ignored meanwhile.
//  Latency: req seen at edge k -> gnt high during cycle k+1 (1 cycle).
//   Min spacing between grants = GAP+2 cycles (GAP=0: one grant every 2 cycles).
//  Round robin:
//   - Search starts at rr_ptr, ascending, wrapping NUM_REQ-1 -> 0.
//   - On grant, rr_ptr <= winner+1 (mod NUM_REQ).
//   - Single requester is re-granted every GAP+2 cycles.
//  Requester contract: drop req the cycle after gnt. A req still high in IDLE is
//   a new request; no error flag.
//  Fold (computed at capture from rand_in/max_val sampled at edge k):
//   - v = rand_in
//   - if v>max_val: v = v-(max_val+1)
//   - if v still >max_val: v = max_val
//   - max_val=0 -> always 0. No modulo divider.
//  rand_out=0 and gnt=0 in every non-GRANT cycle.
//  grant_cnt increments on the edge entering GRANT.
//  max_val changes while busy affect only the next capture.
// TESTING
//  1 reset=1 for 2 cycles, req=4'b1111 -> gnt=0, rand_out=0, busy=0,
//    grant_cnt=0 throughout.
//  2 GAP=2, req=4'b1111 held -> grants 0001,0010,0100,1000,0001 exactly 4 cycles
//    apart; grant_cnt=5.
//  3 req=4'b0100 only, rand_in=13, max_val=11 -> gnt=0100 one cycle after req,
//    rand_out=1; rand_in=9 -> rand_out=9.
//  4 max_val=2, rand_in=15 -> rand_out=2 (clamp); max_val=0, rand_in=7 -> 0.
//  5 reset asserted during GRANT cycle -> next cycle gnt=0, busy=0, rr_ptr=0;
//    req=0010 after release -> gnt=0010.
//  6 GAP=0, req=0011 held -> gnt alternates 0001/0010 every 2 cycles;
//    260 grants -> grant_cnt wraps to 4.

Source files
------------

// File: rtl/random_request_arbiter.sv
// random_request_arbiter
//   Shares one random source among several requesters. Requests are served
//   round-robin, one winner per grant. The winner's random value is folded
//   into the range 0..max_val without a divider. After each grant the arbiter
//   waits GAP idle cycles so the random source advances between draws.
// Ports
//   clk        system clock
//   reset      synchronous reset, active-high
//   req        level request per requester, held until granted
//   rand_in    current random generator value
//   max_val    inclusive upper bound of the delivered value
//   gnt        one-hot grant, one-cycle pulse
//   rand_out   folded random value, valid only while |gnt
//   busy       high whenever the arbiter is not idle
//   grant_cnt  grants since reset, wraps 255 -> 0
module random_request_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned RAND_W  = 4,
  parameter int unsigned GAP     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [RAND_W-1:0]  rand_in,
  input  logic [RAND_W-1:0]  max_val,
  output logic [NUM_REQ-1:0] gnt,
  output logic [RAND_W-1:0]  rand_out,
  output logic               busy,
  output logic [7:0]         grant_cnt
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GAP_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [RAND_W-1:0]  r_rand, w_rand_nxt;
  logic [CNT_W-1:0]   r_grant_cnt, w_grant_cnt_nxt;
  logic               r_busy;

  logic               w_found;
  logic [PTR_W-1:0]   w_winner;
  logic [PTR_W-1:0]   w_idx;
  logic [RAND_W-1:0]  w_sub;
  logic [RAND_W-1:0]  w_fold;

  // Round-robin search: first active request at or after rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_idx = PTR_W'((32'(r_rr_ptr) + off) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Fold: one conditional subtraction of (max_val+1), then clamp to max_val.
  // The subtraction is only used when rand_in > max_val, so it cannot go negative.
  always_comb begin
    w_sub = rand_in - max_val - RAND_W'(1);
    if (rand_in <= max_val) begin
      w_fold = rand_in;
    end else if (w_sub > max_val) begin
      w_fold = max_val;
    end else begin
      w_fold = w_sub;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = '0;
    w_rand_nxt      = '0;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_grant_cnt_nxt = r_grant_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt     = S_GRANT;
          w_gnt_nxt       = NUM_REQ'(1) << w_winner;
          w_rand_nxt      = w_fold;
          w_rr_ptr_nxt    = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);
          w_grant_cnt_nxt = r_grant_cnt + CNT_W'(1);
        end
      end
      S_GRANT: begin
        if (GAP > 0) begin
          w_state_nxt   = S_WAIT;
          w_gap_cnt_nxt = GAP_W'(GAP) - GAP_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_gap_cnt   <= '0;
      r_gnt       <= '0;
      r_rand      <= '0;
      r_grant_cnt <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rand      <= w_rand_nxt;
      r_grant_cnt <= w_grant_cnt_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign gnt       = r_gnt;
  assign rand_out  = r_rand;
  assign busy      = r_busy;
  assign grant_cnt = r_grant_cnt;

endmodule

// File: tb/tb_random_request_arbiter.sv
// Bench for random_request_arbiter: two instances (GAP=2 and GAP=0) share
// inputs; a per-instance reference model tracks cooldown, pointer and counts.
module tb_random_request_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned RW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [NR-1:0] req;
  logic [RW-1:0] rand_in;
  logic [RW-1:0] max_val;

  logic [NR-1:0] gnt_a, gnt_b;
  logic [RW-1:0] rand_a, rand_b;
  logic          busy_a, busy_b;
  logic [7:0]    cnt_a, cnt_b;

  random_request_arbiter #(.NUM_REQ(NR), .RAND_W(RW), .GAP(2)) u_dut_gap2 (
    .clk(clk), .reset(reset), .req(req), .rand_in(rand_in), .max_val(max_val),
    .gnt(gnt_a), .rand_out(rand_a), .busy(busy_a), .grant_cnt(cnt_a)
  );

  random_request_arbiter #(.NUM_REQ(NR), .RAND_W(RW), .GAP(0)) u_dut_gap0 (
    .clk(clk), .reset(reset), .req(req), .rand_in(rand_in), .max_val(max_val),
    .gnt(gnt_b), .rand_out(rand_b), .busy(busy_b), .grant_cnt(cnt_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: cooldown = cycles until the arbiter accepts again.
  int         gap_of[2] = '{2, 0};
  int         cool[2];
  int         ptr[2];
  int         tot[2];
  logic [3:0] eg[2];
  logic [3:0] er[2];

  function automatic int fold(input int v, input int m);
    int r;
    r = v;
    if (r > m) r = r - (m + 1);
    if (r > m) r = m;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        cool[d] = 0; ptr[d] = 0; tot[d] = 0; eg[d] = '0; er[d] = '0;
      end else if (cool[d] == 0 && req != '0) begin
        int w;
        w = -1;
        for (int off = 0; off < NR; off++) begin
          int i;
          i = (ptr[d] + off) % NR;
          if (w < 0 && req[i]) w = i;
        end
        eg[d]   = 4'(1 << w);
        er[d]   = 4'(fold(int'(rand_in), int'(max_val)));
        tot[d]  = tot[d] + 1;
        ptr[d]  = (w + 1) % NR;
        cool[d] = gap_of[d] + 1;
      end else begin
        eg[d] = '0;
        er[d] = '0;
        if (cool[d] > 0) cool[d] = cool[d] - 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt_gap2",  32'(gnt_a),  32'(eg[0]));
    chk("rand_gap2", 32'(rand_a), 32'(er[0]));
    chk("busy_gap2", 32'(busy_a), 32'(cool[0] > 0));
    chk("cnt_gap2",  32'(cnt_a),  32'(tot[0] % 256));
    chk("gnt_gap0",  32'(gnt_b),  32'(eg[1]));
    chk("rand_gap0", 32'(rand_b), 32'(er[1]));
    chk("busy_gap0", 32'(busy_b), 32'(cool[1] > 0));
    chk("cnt_gap0",  32'(cnt_b),  32'(tot[1] % 256));
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset   = 1'b1;
    req     = 4'b1111;
    rand_in = 4'd5;
    max_val = 4'd15;

    // Reset held two cycles with all requests active.
    step();
    step();
    chk("reset_gnt", 32'(gnt_a), 32'd0);
    chk("reset_cnt", 32'(cnt_a), 32'd0);

    // Round-robin across all requesters, GAP=2.
    reset = 1'b0;
    for (int n = 0; n < 100 && tot[0] < 5; n++) begin
      rand_in = 4'($urandom);
      step();
    end
    chk("rr_cnt5", 32'(cnt_a), 32'd5);
    chk("rr_last", 32'(gnt_a), 32'b0001);
    idle(6);

    // Fold: subtract branch and pass-through.
    rand_in = 4'd13; max_val = 4'd11; req = 4'b0100;
    step();
    chk("fold13_gnt", 32'(gnt_a), 32'b0100);
    chk("fold13_val", 32'(rand_a), 32'd1);
    idle(5);
    rand_in = 4'd9; req = 4'b0100;
    step();
    chk("fold9_val", 32'(rand_a), 32'd9);
    idle(5);

    // Fold: clamp and max_val=0.
    rand_in = 4'd15; max_val = 4'd2; req = 4'b0100;
    step();
    chk("clamp_val", 32'(rand_a), 32'd2);
    idle(5);
    rand_in = 4'd7; max_val = 4'd0; req = 4'b0100;
    step();
    chk("max0_val", 32'(rand_a), 32'd0);
    idle(5);

    // Reset during a GRANT cycle clears the pointer.
    req = 4'b1111; max_val = 4'd9;
    for (int n = 0; n < 20; n++) begin
      step();
      if (eg[0] == 4'b0100) break;
    end
    reset = 1'b1;
    step();
    chk("rst_mid_gnt",  32'(gnt_a),  32'd0);
    chk("rst_mid_busy", 32'(busy_a), 32'd0);
    reset = 1'b0;
    req   = 4'b1111;
    step();
    chk("rst_ptr0", 32'(gnt_a), 32'b0001);
    idle(5);
    req = 4'b0010;
    step();
    chk("rst_req2", 32'(gnt_a), 32'b0010);
    idle(5);

    // GAP=0 alternation and counter wrap after 260 grants.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b0011;
    for (int n = 0; n < 600 && tot[1] < 260; n++) begin
      rand_in = 4'($urandom);
      max_val = 4'($urandom);
      step();
    end
    chk("wrap_cnt", 32'(cnt_b), 32'd4);
    idle(4);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      req     = 4'($urandom);
      rand_in = 4'($urandom);
      max_val = 4'($urandom);
      reset   = ($urandom_range(0, 59) == 0);
      step();
    end
    reset = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
